// File: rtl/key_filter_pkg.sv
// Shared types and constants for the key debouncer.
// KEY_FILTER_LONG_PRESS_EN adds the long-press default.
`timescale 1ns/1ps
package key_filter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FILTER0 = 2'b01,
        DOWN    = 2'b10,
        FILTER1 = 2'b11
    } state_t;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    localparam int unsigned CNT_MAX_DEFAULT = 999_999;
    localparam int unsigned CNT_W_DEFAULT   = 20;

`ifdef KEY_FILTER_LONG_PRESS_EN
    localparam int unsigned LONG_CNT_MAX_DEFAULT = 49_999_999;
`endif

endpackage

// File: rtl/key_filter_if.sv
// Key debouncer signal bundle: raw key in, clean level and event pulses out.
// KEY_FILTER_LONG_PRESS_EN adds long_flag.
`timescale 1ns/1ps
interface key_filter_if;
    logic key_in;
    logic key_flag;
    logic key_state;
`ifdef KEY_FILTER_LONG_PRESS_EN
    logic long_flag;

    modport master (output key_in, input key_flag, input key_state, input long_flag);
    modport slave  (input key_in, output key_flag, output key_state, output long_flag);
`else
    modport master (output key_in, input key_flag, input key_state);
    modport slave  (input key_in, output key_flag, output key_state);
`endif
endinterface

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for the raw key plus one history register for edges.
`timescale 1ns/1ps
module key_sync_edge (
    input  logic Clk,
    input  logic Rst_n,
    input  logic key_in,
    output logic key_sync,
    output logic nedge,
    output logic pedge
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Reset to the released level so a held-released key produces no edge.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign key_sync = sync2;
    assign nedge    = sync3 & ~sync2;
    assign pedge    = ~sync3 & sync2;

endmodule

// File: rtl/key_filter.sv
// Key debouncer: stable-time FSM producing a clean level and press/release pulses.
// KEY_FILTER_LONG_PRESS_EN adds a one-shot long_flag after LONG_CNT_MAX+1 clocks in DOWN.
`timescale 1ns/1ps
module key_filter
    import key_filter_pkg::*;
#(
    parameter int unsigned CNT_MAX      = CNT_MAX_DEFAULT,
    parameter int unsigned CNT_W        = CNT_W_DEFAULT
`ifdef KEY_FILTER_LONG_PRESS_EN
   ,parameter int unsigned LONG_CNT_MAX = LONG_CNT_MAX_DEFAULT
`endif
) (
    input  logic         Clk,
    input  logic         Rst_n,
    key_filter_if.slave  kif
);

    logic key_sync;
    logic nedge;
    logic pedge;

    key_sync_edge u_sync (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .key_in   (kif.key_in),
        .key_sync (key_sync),
        .nedge    (nedge),
        .pedge    (pedge)
    );

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             key_flag_q;
    logic             key_flag_nxt;
    logic             key_state_q;
    logic             key_state_nxt;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            key_flag_q  <= 1'b0;
            key_state_q <= KEY_RELEASED;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_flag_q  <= key_flag_nxt;
            key_state_q <= key_state_nxt;
        end
    end

    // An opposite edge is checked before count completion so it always wins.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        key_flag_nxt  = 1'b0;
        key_state_nxt = ((state == DOWN) || (state == FILTER1)) ? KEY_PRESSED : KEY_RELEASED;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (nedge) begin
                    state_nxt = FILTER0;
                end
            end
            FILTER0: begin
                if (pedge) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(CNT_MAX)) begin
                    cnt_nxt = '0;
                    if (key_sync == KEY_PRESSED) begin
                        state_nxt    = DOWN;
                        key_flag_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DOWN: begin
                cnt_nxt = '0;
                if (pedge) begin
                    state_nxt = FILTER1;
                end
            end
            FILTER1: begin
                if (nedge) begin
                    state_nxt = DOWN;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(CNT_MAX)) begin
                    cnt_nxt = '0;
                    if (key_sync == KEY_RELEASED) begin
                        state_nxt    = IDLE;
                        key_flag_nxt = 1'b1;
                    end else begin
                        state_nxt = DOWN;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign kif.key_flag  = key_flag_q;
    assign kif.key_state = key_state_q;

`ifdef KEY_FILTER_LONG_PRESS_EN
    // One extra count value beyond LONG_CNT_MAX marks "already fired this press".
    localparam int unsigned LONG_W = $clog2(LONG_CNT_MAX + 2);

    logic [LONG_W-1:0] long_cnt;
    logic              long_flag_q;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            long_cnt    <= '0;
            long_flag_q <= 1'b0;
        end else begin
            long_flag_q <= 1'b0;
            if ((state == DOWN) && (state_nxt == DOWN)) begin
                if (long_cnt != LONG_W'(LONG_CNT_MAX + 1)) begin
                    long_cnt <= long_cnt + LONG_W'(1);
                end
                if (long_cnt == LONG_W'(LONG_CNT_MAX)) begin
                    long_flag_q <= 1'b1;
                end
            end else begin
                long_cnt <= '0;
            end
        end
    end

    assign kif.long_flag = long_flag_q;
`endif

endmodule
